pipeline_control_unit: RTL

// Sequences the decode stage of the RV32E pipeline.
// - Holds a per-register scoreboard of pending writebacks and stalls decode issue on RAW/WAW hazards.
// - On an execute-stage redirect it generates the decoder/fetch flush and the fetch redirect.
// - On a decode error it drains in-flight work and halts the core with a sticky fault.

---
 rtl/pipeline_control_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipeline_control_unit.sv
// Decode-stage sequencer for the RV32E pipeline: writeback scoreboard with RAW/WAW
// issue stall, redirect flush/refetch, and decode-error drain-to-halt.

module pcu_reg_slot #(
  parameter int CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic release_wb
);
  logic [CNT_W-1:0] cnt;

  assign busy       = (cnt != '0);
  assign full       = (cnt == {CNT_W{1'b1}});
  // A writeback against an idle register is dropped rather than wrapping the count.
  assign release_wb = dec && busy;

  always_ff @(posedge clock) begin
    if (reset)                     cnt <= '0;
    else if (inc && !release_wb)   cnt <= cnt + CNT_W'(1);
    else if (release_wb && !inc)   cnt <= cnt - CNT_W'(1);
  end
endmodule

module pipeline_control_unit #(
  parameter int NUM_REGS     = 16,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rs1,
  input  logic                        issue_rs1_used,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rs2,
  input  logic                        issue_rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  input  logic                        issue_writes_rd,
  output logic                        issue_ready,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
  input  logic                        decode_error,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_target,
  output logic                        flush,
  output logic                        fetch_redirect,
  output logic [ADDR_W-1:0]           fetch_target,
  output logic                        fault
);
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int IF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam int FC_W   = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t              state;
  logic [FC_W-1:0]     flush_cnt;
  logic [IF_W-1:0]     inflight;
  logic [NUM_REGS-1:0] busy_vec, full_vec, rel_vec;
  logic                hazard, fire, issue_inc, wb_live, wb_rel;

  assign hazard = (issue_rs1_used && issue_rs1 != '0 && busy_vec[issue_rs1]) ||
                  (issue_rs2_used && issue_rs2 != '0 && busy_vec[issue_rs2]) ||
                  (issue_writes_rd && issue_rd != '0 && full_vec[issue_rd]) ||
                  (inflight == IF_W'(MAX_INFLIGHT));

  assign issue_ready = !reset && (state == RUN) && !hazard && !redirect_valid && !decode_error;
  assign fire        = issue_valid && issue_ready;
  assign issue_inc   = fire && issue_writes_rd && (issue_rd != '0);
  // Once halted the scoreboard is frozen until reset.
  assign wb_live     = wb_valid && (state != HALTED);
  assign wb_rel      = |rel_vec;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_x0
      assign busy_vec[r] = 1'b0;
      assign full_vec[r] = 1'b0;
      assign rel_vec[r]  = 1'b0;
    end else begin : g_slot
      pcu_reg_slot #(.CNT_W(CNT_W)) u_slot (
        .clock      (clock),
        .reset      (reset),
        .inc        (issue_inc && (issue_rd == RIDX_W'(r))),
        .dec        (wb_live && (wb_rd == RIDX_W'(r))),
        .busy       (busy_vec[r]),
        .full       (full_vec[r]),
        .release_wb (rel_vec[r])
      );
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                    inflight <= '0;
    else if (issue_inc && !wb_rel) inflight <= inflight + IF_W'(1);
    else if (wb_rel && !issue_inc) inflight <= inflight - IF_W'(1);
  end

  // Redirect entry loads the full count so flush covers the pulse cycle plus FLUSH_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      flush_cnt      <= '0;
      flush          <= 1'b0;
      fetch_redirect <= 1'b0;
      fetch_target   <= '0;
      fault          <= 1'b0;
    end else begin
      fetch_redirect <= 1'b0;
      case (state)
        RUN, DRAIN, FLUSH: begin
          if (redirect_valid) begin
            state          <= FLUSH;
            flush_cnt      <= FC_W'(FLUSH_CYCLES);
            flush          <= 1'b1;
            fetch_redirect <= 1'b1;
            fetch_target   <= redirect_target;
          end else if (state == FLUSH) begin
            if (flush_cnt == '0) begin
              state <= RUN;
              flush <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end else if (state == RUN) begin
            if (decode_error) state <= DRAIN;
          end else if (inflight == '0) begin
            state <= HALTED;
            fault <= 1'b1;
          end
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end
endmodule
